// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: fetch FSM states, PC mux selects, reset/NOP
// constants and the major opcodes the control unit decodes.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: async reset, load enable, and a next-value mux
// choosing between hold, sequential increment and an aligned target.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_loadEn,
  input  pc_sel_t     i_sel,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] w_pcPlus4;

  // Natural 32-bit wrap gives FFFF_FFFC + 4 = 0000_0000.
  assign w_pcPlus4 = r_pc + 32'd4;

  always_comb begin
    w_pcNext = r_pc;
    unique case (i_sel)
      PC_INC:    w_pcNext = w_pcPlus4;
      PC_TARGET: w_pcNext = wordAlign(i_target);
      default:   w_pcNext = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_loadEn) begin
      r_pc <= w_pcNext;
    end
  end

  assign o_pc      = r_pc;
  assign o_pcPlus4 = w_pcPlus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake, holds
// the fetched word for decode and squashes responses made stale by a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  fetch_state_t r_state;
  fetch_state_t w_stateNext;

  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_pendTarget;

  logic [31:0] w_instrNext;
  logic        w_validNext;
  logic [31:0] w_pendNext;
  logic        w_reqState;
  logic        w_pcLoad;
  pc_sel_t     w_pcSel;
  logic [31:0] w_pcTarget;
  logic [31:0] w_pc;
  logic [31:0] w_pcPlus4;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .clk       (clk),
    .rst       (rst),
    .i_loadEn  (w_pcLoad),
    .i_sel     (w_pcSel),
    .i_target  (w_pcTarget),
    .o_pc      (w_pc),
    .o_pcPlus4 (w_pcPlus4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_instr      <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_pendTarget <= 32'h0000_0000;
    end else begin
      r_state      <= w_stateNext;
      r_instr      <= w_instrNext;
      r_valid      <= w_validNext;
      r_pendTarget <= w_pendNext;
    end
  end

  // In DRAIN the PC is deliberately left at the stale address so the
  // outstanding request stays stable until memory acknowledges it.
  always_comb begin
    w_stateNext = r_state;
    w_instrNext = r_instr;
    w_validNext = r_valid;
    w_pendNext  = r_pendTarget;
    w_reqState  = 1'b0;
    w_pcLoad    = 1'b0;
    w_pcSel     = PC_HOLD;
    w_pcTarget  = redirect_target;

    unique case (r_state)
      FETCH: begin
        w_reqState = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            w_pcLoad = 1'b1;
            w_pcSel  = PC_TARGET;
          end else begin
            w_instrNext = imem_rdata;
            w_validNext = 1'b1;
            w_stateNext = HOLD;
          end
        end else if (redirect) begin
          w_pendNext  = wordAlign(redirect_target);
          w_stateNext = DRAIN;
        end
      end

      DRAIN: begin
        w_reqState = 1'b1;
        if (imem_ack) begin
          w_pcLoad    = 1'b1;
          w_pcSel     = PC_TARGET;
          w_pcTarget  = redirect ? redirect_target : r_pendTarget;
          w_stateNext = FETCH;
        end else if (redirect) begin
          w_pendNext = wordAlign(redirect_target);
        end
      end

      HOLD: begin
        if (redirect) begin
          w_pcLoad    = 1'b1;
          w_pcSel     = PC_TARGET;
          w_validNext = 1'b0;
          w_instrNext = NOP_INSTR;
          w_stateNext = FETCH;
        end else if (!stall) begin
          w_pcLoad    = 1'b1;
          w_pcSel     = PC_INC;
          w_validNext = 1'b0;
          w_instrNext = NOP_INSTR;
          w_stateNext = FETCH;
        end
      end

      default: begin
        w_stateNext = FETCH;
      end
    endcase
  end

  // Reset withdraws the request at once rather than waiting for a clock.
  assign imem_req    = w_reqState & ~rst;
  assign imem_addr   = w_pc;
  assign instr_valid = r_valid;
  assign instruction = r_instr;
  assign pc          = w_pc;
  assign pc_plus4    = w_pcPlus4;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the decode/register-read stage of the RV32I core. It owns the program counter and issues word requests to instruction memory with a req/ack handshake. It holds each fetched instruction, with its PC, until decode accepts it. It also applies taken-branch/jump redirects coming back from execute, and discards any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven when nothing is valid (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word address of request, low 2 bits always 0
imem_ack  input  1  memory response valid; imem_rdata sampled this cycle
imem_rdata  input  32  fetched instruction word
stall  input  1  decode cannot accept the presented instruction this cycle
redirect  input  1  taken branch/jump from execute, one-cycle pulse
redirect_target  input  32  new PC; bits [1:0] ignored (treated as 0)
instr_valid  output  1  instruction/pc outputs hold a valid fetched instruction
instruction  output  32  to decode (control unit instruction input)
pc  output  32  address of the presented instruction
pc_plus4  output  32  pc + 4, modulo 2^32 (link value for jal/jalr)

Behaviour:
- States: FETCH (request outstanding), HOLD (instruction presented), DRAIN (discard stale response).
- Reset, asynchronous: state=FETCH, pc=RESET_PC, instruction=NOP_INSTR, instr_valid=0, pend_target=0. imem_req is combinational: it is 1 in FETCH and DRAIN.
- imem_addr is combinational. It is pc in FETCH and the frozen stale address in DRAIN. It stays stable while imem_req=1 until ack.
- FETCH:
  - imem_ack=1 and redirect=0: instruction<=imem_rdata, instr_valid<=1, go to HOLD. An ack in the same cycle as the request is legal, giving a minimum of 2 cycles per instruction.
  - imem_ack=1 and redirect=1: discard rdata, pc<={target[31:2],2'b00}, stay in FETCH.
  - imem_ack=0 and redirect=1: latch pend_target, go to DRAIN. The pc register keeps the stale address so imem_addr stays stable.
- DRAIN:
  - On imem_ack: discard rdata, pc<=pend_target, go to FETCH.
  - A redirect while in DRAIN overwrites pend_target (the latest redirect wins).
  - If imem_ack and redirect occur together in DRAIN, the new target is used directly.
- HOLD, with instr_valid=1:
  - redirect=1 (takes priority over stall): pc<=target, instr_valid<=0, instruction<=NOP_INSTR, go to FETCH.
  - stall=0 and redirect=0: pc<=pc+4 (wraps FFFF_FFFC to 0000_0000), instr_valid<=0, instruction<=NOP_INSTR, go to FETCH.
  - stall=1 and redirect=0: hold all outputs unchanged.
- imem_ack outside FETCH/DRAIN is ignored.
- stall has no effect outside HOLD.
- Reset mid-transaction drops the request immediately. The memory side must ignore a request withdrawn by reset.
- pc_plus4 is always pc+4 of the presented pc, including when instr_valid=0.
- Decode consumes the instruction on any cycle where instr_valid=1 and stall=0.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {FETCH, HOLD, DRAIN};
  - RESET_PC default, NOP_INSTR constant;
  - opcode constants shared with the control unit.
- Sub-module pc_reg: 32-bit PC register with async reset to RESET_PC, load-enable, next-value mux (pc+4 / target / hold) and word-align masking.
- FSM and handshake logic stay in fetch_unit.

Test Plan:
1. Reset released, imem_ack tied 1, imem_rdata=32'h0050_0093 -> first cycle imem_addr=0. Next cycle instr_valid=1, instruction=0050_0093, pc=0, pc_plus4=4. Then imem_addr=4 two cycles later.
2. Ack delayed 3 cycles with stall=0 -> imem_req held 3 cycles with imem_addr constant at 0x0000_0008. instr_valid rises one cycle after ack.
3. In HOLD at pc=0x10, stall=1 for 4 cycles -> outputs frozen and imem_req=0. Release stall -> next request address is 0x14.
4. redirect=1 with target 0x0000_0103 while FETCH is pending with ack=0 -> DRAIN. Stale ack data is not presented; the next request address is 0x0000_0100.
5. Redirect to 0x200 during HOLD with stall=1 -> instr_valid drops, instruction=0000_0013, next request address 0x200.
6. pc=0xFFFF_FFFC accepted -> next request address 0x0000_0000. Assert rst mid-FETCH -> imem_req=0 immediately and pc=RESET_PC.
